store_order_tracker: RTL

Tracks outstanding stores between the store unit and the write-through data cache write buffer, and gates loads and fences according to a configurable memory-ordering mode. It generalises the fixed single-outstanding-store behaviour to N outstanding stores with per-store transaction IDs. It adds a line-granular relaxed mode and a fence-drain state machine.

---
 rtl/memorder_pkg.sv | 31 +++
 rtl/lzc.sv | 27 ++
 rtl/store_order_tracker.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/memorder_pkg.sv
// Shared types for the store ordering tracker.
//   st_entry_t    : one outstanding-store record (valid, line address, TID)
//   fence_state_e : fence drain state machine states
//   line_addr()   : strips the in-line offset bits from a physical address
// Widths here are upper bounds; instantiating modules zero-extend into them,
// so AddrWidth must not exceed MaxAddrWidth and TidWidth must not exceed MaxTidWidth.
package memorder_pkg;

  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned MaxTidWidth  = 8;

  typedef logic [MaxAddrWidth-1:0] line_addr_t;

  typedef struct packed {
    logic                   valid;
    line_addr_t             line;
    logic [MaxTidWidth-1:0] tid;
  } st_entry_t;

  typedef enum logic [1:0] {
    FENCE_IDLE,
    FENCE_DRAIN,
    FENCE_DONE
  } fence_state_e;

  function automatic line_addr_t line_addr(input logic [MaxAddrWidth-1:0] addr,
                                           input int unsigned             offset_bits);
    return addr >> offset_bits;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter.
//   in_i    : vector to scan
//   cnt_o   : number of zeros before the first set bit (from LSB when MODE=0,
//             from MSB when MODE=1); 0 when in_i is all zeros
//   empty_o : in_i has no set bit
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CntWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]    in_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o
);

  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (empty_o && in_i[MODE ? (WIDTH - 1 - i) : i]) begin
        cnt_o   = CntWidth'(i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/store_order_tracker.sv
// Tracks outstanding stores between the store unit and the write buffer and
// gates loads and fences according to the memory-ordering mode.
//   clk_i / rst_ni         : clock, asynchronous active-low reset
//   flush_i                : synchronous clear of all entries and the fence FSM
//   st_req_*               : store issue handshake; st_req_tid_o is the TID granted
//   st_ack_*               : write buffer acknowledge by TID
//   ld_req_*               : load issue permission (ready is combinational)
//   fence_i / fence_done_o : fence request and one-cycle drained pulse
//   count_o / empty_o      : registered outstanding-store count
//   err_ack_o              : one-cycle pulse after an ack to an invalid TID
module store_order_tracker
  import memorder_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 1,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned LineOffsetBits = 4,
  parameter bit          SeqConsistent  = 1'b1,
  localparam int unsigned CountWidth    = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  st_req_valid_i,
  input  logic [AddrWidth-1:0]  st_req_addr_i,
  output logic                  st_req_ready_o,
  output logic [TidWidth-1:0]   st_req_tid_o,
  input  logic                  st_ack_valid_i,
  input  logic [TidWidth-1:0]   st_ack_tid_i,
  input  logic                  ld_req_valid_i,
  input  logic [AddrWidth-1:0]  ld_req_addr_i,
  output logic                  ld_req_ready_o,
  input  logic                  fence_i,
  output logic                  fence_done_o,
  output logic [CountWidth-1:0] count_o,
  output logic                  empty_o,
  output logic                  err_ack_o
);

  localparam int unsigned IdxWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  st_entry_t                entry_q [MaxOutstanding];
  logic [MaxOutstanding-1:0] free_vec;
  logic [MaxOutstanding-1:0] ack_hit;
  logic [MaxOutstanding-1:0] alloc_hit;
  logic [MaxOutstanding-1:0] ld_hit;
  logic [IdxWidth-1:0]       alloc_idx;
  logic                      table_full;
  logic                      accept;
  logic                      ack_ok;
  logic [CountWidth-1:0]     count_q, count_d;
  logic                      empty_q;
  logic                      err_q;
  fence_state_e              state_q, state_d;
  logic                      fence_drain;
  line_addr_t                st_line;
  line_addr_t                ld_line;

  // Load permission never depends on whether a load is actually pending.
  logic unused_ld_valid;
  assign unused_ld_valid = ld_req_valid_i;

  assign st_line = line_addr(MaxAddrWidth'(st_req_addr_i), LineOffsetBits);
  assign ld_line = line_addr(MaxAddrWidth'(ld_req_addr_i), LineOffsetBits);

  // Lowest free entry wins the allocation.
  lzc #(
    .WIDTH (MaxOutstanding),
    .MODE  (1'b0)
  ) i_free_lzc (
    .in_i    (free_vec),
    .cnt_o   (alloc_idx),
    .empty_o (table_full)
  );

  // Ready looks only at registered state, so an entry freed by this cycle's
  // ack cannot be handed out again until the next cycle.
  assign st_req_ready_o = ~table_full & ~fence_drain;
  assign st_req_tid_o   = table_full ? '0 : TidWidth'(alloc_idx);
  assign accept         = st_req_valid_i & st_req_ready_o;
  assign ack_ok         = |ack_hit;

  // TIDs above the table size can never match a stored TID, so the range
  // check falls out of the per-entry compare.
  always_comb begin
    free_vec  = '0;
    ack_hit   = '0;
    alloc_hit = '0;
    ld_hit    = '0;
    for (int unsigned i = 0; i < MaxOutstanding; i++) begin
      free_vec[i]  = ~entry_q[i].valid;
      ack_hit[i]   = st_ack_valid_i & entry_q[i].valid
                   & (32'(entry_q[i].tid) == 32'(st_ack_tid_i));
      alloc_hit[i] = accept & (alloc_idx == IdxWidth'(i));
      ld_hit[i]    = entry_q[i].valid & (entry_q[i].line == ld_line);
    end
  end

  assign ld_req_ready_o = SeqConsistent ? empty_q : ~(|ld_hit);

  // Entry table. An entry's TID is its index and is fixed at reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        entry_q[i].valid <= 1'b0;
        entry_q[i].line  <= '0;
        entry_q[i].tid   <= MaxTidWidth'(i);
      end
    end else begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        if (flush_i) begin
          entry_q[i].valid <= 1'b0;
        end else if (ack_hit[i]) begin
          entry_q[i].valid <= 1'b0;
        end else if (alloc_hit[i]) begin
          entry_q[i].valid <= 1'b1;
          entry_q[i].line  <= st_line;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (accept && !ack_ok) begin
      count_d = count_q + CountWidth'(1);
    end else if (!accept && ack_ok) begin
      count_d = count_q - CountWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      err_q <= st_ack_valid_i & ~ack_ok;
      if (flush_i) begin
        count_q <= '0;
        empty_q <= 1'b1;
      end else begin
        count_q <= count_d;
        empty_q <= (count_d == '0);
      end
    end
  end

  assign count_o   = count_q;
  assign empty_o   = empty_q;
  assign err_ack_o = err_q;

  // Fence FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FENCE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fence FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FENCE_IDLE:  if (fence_i) state_d = FENCE_DRAIN;
      FENCE_DRAIN: if (empty_q) state_d = FENCE_DONE;
      FENCE_DONE:  state_d = FENCE_IDLE;
      default:     state_d = FENCE_IDLE;
    endcase
    if (flush_i) begin
      state_d = FENCE_IDLE;
    end
  end

  // Fence FSM: outputs
  always_comb begin
    fence_drain  = (state_q == FENCE_DRAIN);
    fence_done_o = (state_q == FENCE_DONE);
  end

endmodule
